pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5: register-address width.
REQ-002 Parameter N_SRC, default 2: source operands per instruction, each with its own forwarding select.
REQ-003 Parameter CNT_W, default 16: width of each performance counter.
REQ-004 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port id_valid  input  1: a real instruction is in ID.
REQ-007 Port id_src  input  N_SRC*ADDR_W: ID source addresses; slot k is bits [k*ADDR_W +: ADDR_W].
REQ-008 Port id_src_used  input  N_SRC: bit k high means slot k is read.
REQ-009 Port id_rd, id_regwrite, id_memread  input  ADDR_W/1/1: ID destination, register-write and load flags.
REQ-010 Port id_jump  input  1: ID holds a jump.
REQ-011 Port mem_branch_taken  input  1: branch in MEM is taken.
REQ-012 Port pc_en, ifid_en  output  1/1: PC and IF/ID load enables.
REQ-013 Port ifid_flush, idex_flush, exmem_flush  output  1 each: zero the control fields of that pipeline register on the next edge.
REQ-014 Port fwd_sel  output  2*N_SRC: per-slot select for the EX operand: 00 register file, 01 MEM/WB, 10 EX/MEM; 11 never driven.
REQ-015 Port stall_cnt, flush_cnt  output  CNT_W each: performance counters.

Function
REQ-016 Shadow stages EX, MEM, WB each SHALL hold {valid, rd, regwrite}; EX SHALL also hold memread, src and src_used.
REQ-017 Each clock, ID SHALL advance to EX, EX to MEM and MEM to WB, unless a rule below overrides this.
REQ-018 Load-use stall SHALL be raised when all hold:
- id_valid is high;
- EX is valid with memread high;
- the EX rd is non-zero;
- the EX rd equals some used id_src slot.
REQ-019 During a stall:
- pc_en=0, ifid_en=0 and idex_flush=1;
- EX receives a bubble (valid=0);
- EX moves to MEM normally.
REQ-020 A stall SHALL last exactly one cycle per load-use pair.
REQ-021 When mem_branch_taken=1:
- ifid_flush, idex_flush and exmem_flush SHALL be 1 and pc_en=1;
- the EX and MEM shadow entries SHALL be loaded invalid on that edge;
- the WB shadow stage SHALL load the retiring MEM entry.
REQ-022 When id_jump=1 and id_valid=1 with no stall or redirect: ifid_flush=1, pc_en=1, no other flush.
REQ-023 Priority SHALL be redirect, then stall, then jump; a stall coincident with a redirect SHALL be dropped.
REQ-024 fwd_sel slot k SHALL be 10 when all hold:
- MEM is valid with regwrite high;
- the MEM rd is non-zero;
- the MEM rd equals EX src k;
- EX src_used k is high.
REQ-025 Otherwise fwd_sel slot k SHALL be 01 under the same test against WB, else 00; MEM outranks WB.
REQ-026 Register address 0 SHALL never be forwarded or cause a stall.
REQ-027 fwd_sel SHALL be combinational from shadow state only; stall and flush outputs SHALL be combinational from inputs and shadow state.
REQ-028 stall_cnt SHALL increment once per stall cycle and flush_cnt once per redirect or jump cycle.
REQ-029 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-030 While reset=1, irrespective of clk:
- all shadow valid bits are 0;
- all counters are 0;
- fwd_sel is all 00 and the flush outputs are 0;
- pc_en=1 and ifid_en=1.
REQ-031 A reset asserted mid-stall or mid-flush SHALL abort it immediately.
REQ-032 The first edge after reset release SHALL behave as an empty pipeline.

Verification
REQ-033 lw $2 then add $3,$2,$4 -> exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle fwd_sel slot0=01; stall_cnt=1.
REQ-034 add $5 back-to-back with sub $6,$5,$5 -> no stall; fwd_sel=1010 (both slots EX/MEM).
REQ-035 add $5, nop, or $7,$5,$1 -> fwd_sel slot0=01; with $5 also written by the middle instruction -> slot0=10.
REQ-036 Writer to $0 followed by a reader of $0 -> fwd_sel=0000, no stall.
REQ-037 mem_branch_taken=1 on the same cycle as load-use and id_jump -> all three flushes=1, pc_en=1, stall_cnt unchanged, flush_cnt+1.
REQ-038 CNT_W=2 with 5 stalls -> stall_cnt=3; then assert reset asynchronously between edges -> counters 0 and all flushes 0 at once.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush and EX operand forwarding.
// Keeps a shadow copy of the EX/MEM/WB destination info and counts stall/flush cycles.
module pipe_hazard_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned N_SRC  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [N_SRC*ADDR_W-1:0]   id_src,
    input  logic [N_SRC-1:0]          id_src_used,
    input  logic [ADDR_W-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic                      id_jump,
    input  logic                      mem_branch_taken,
    output logic                      pc_en,
    output logic                      ifid_en,
    output logic                      ifid_flush,
    output logic                      idex_flush,
    output logic                      exmem_flush,
    output logic [2*N_SRC-1:0]        fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    localparam int unsigned SRC_W = N_SRC * ADDR_W;

    logic                ex_valid, ex_regwrite, ex_memread;
    logic [ADDR_W-1:0]   ex_rd;
    logic [SRC_W-1:0]    ex_src;
    logic [N_SRC-1:0]    ex_src_used;
    logic                mem_valid, mem_regwrite;
    logic [ADDR_W-1:0]   mem_rd;
    logic                wb_valid, wb_regwrite;
    logic [ADDR_W-1:0]   wb_rd;

    logic load_use_c;
    logic redirect_c;
    logic stall_c;
    logic jump_c;
    logic ex_load_c;

    // Load in EX whose non-zero destination is read by the instruction in ID
    always_comb begin
        load_use_c = 1'b0;
        if (id_valid && ex_valid && ex_memread && (ex_rd != '0)) begin
            for (int k = 0; k < int'(N_SRC); k++) begin
                if (id_src_used[k] && (id_src[k*ADDR_W +: ADDR_W] == ex_rd))
                    load_use_c = 1'b1;
            end
        end
    end

    // Redirect outranks stall, stall outranks jump; reset forces the idle pattern
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        redirect_c  = 1'b0;
        stall_c     = 1'b0;
        jump_c      = 1'b0;
        if (reset) begin
            pc_en = 1'b1;
        end else if (mem_branch_taken) begin
            redirect_c  = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use_c) begin
            stall_c    = 1'b1;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_jump && id_valid) begin
            jump_c     = 1'b1;
            ifid_flush = 1'b1;
        end
    end

    // MEM/WB writers of a non-zero register feed EX operands; MEM is the younger value
    always_comb begin
        fwd_sel = '0;
        for (int k = 0; k < int'(N_SRC); k++) begin
            if (ex_src_used[k] && mem_valid && mem_regwrite && (mem_rd != '0) &&
                (mem_rd == ex_src[k*ADDR_W +: ADDR_W]))
                fwd_sel[2*k +: 2] = 2'b10;
            else if (ex_src_used[k] && wb_valid && wb_regwrite && (wb_rd != '0) &&
                     (wb_rd == ex_src[k*ADDR_W +: ADDR_W]))
                fwd_sel[2*k +: 2] = 2'b01;
        end
    end

    assign ex_load_c = id_valid && !stall_c && !redirect_c;

    // Bubbles and flushed slots carry no reads, so they never request forwarding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_rd        <= '0;
            ex_src       <= '0;
            ex_src_used  <= '0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_rd       <= '0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= '0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            ex_valid     <= ex_load_c;
            ex_src_used  <= ex_load_c ? id_src_used : '0;
            ex_regwrite  <= id_regwrite;
            ex_memread   <= id_memread;
            ex_rd        <= id_rd;
            ex_src       <= id_src;
            mem_valid    <= ex_valid && !redirect_c;
            mem_regwrite <= ex_regwrite;
            mem_rd       <= ex_rd;
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_rd        <= mem_rd;
            if (stall_c && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if ((redirect_c || jump_c) && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected values queued as stimulus is driven,
// popped and compared when the corresponding outputs are sampled.
module tb_pipe_hazard_ctrl;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned N_SRC  = 2;
    localparam int unsigned CNT_W  = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    id_valid;
    logic [N_SRC*ADDR_W-1:0] id_src;
    logic [N_SRC-1:0]        id_src_used;
    logic [ADDR_W-1:0]       id_rd;
    logic                    id_regwrite, id_memread, id_jump, mem_branch_taken;
    logic                    pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush;
    logic [2*N_SRC-1:0]      fwd_sel;
    logic [CNT_W-1:0]        stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.ADDR_W(ADDR_W), .N_SRC(N_SRC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_jump(id_jump), .mem_branch_taken(mem_branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: got %0h required none", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: got %0h required %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic exp_ctrl(input logic pc, input logic ifid, input logic fi,
                            input logic fx, input logic fm);
        push("pc_en", 32'(pc));
        push("ifid_en", 32'(ifid));
        push("ifid_flush", 32'(fi));
        push("idex_flush", 32'(fx));
        push("exmem_flush", 32'(fm));
    endtask

    task automatic chk_ctrl();
        pop_chk(32'(pc_en));
        pop_chk(32'(ifid_en));
        pop_chk(32'(ifid_flush));
        pop_chk(32'(idex_flush));
        pop_chk(32'(exmem_flush));
    endtask

    task automatic fwd(input logic [3:0] v);
        push("fwd_sel", 32'(v));
        pop_chk(32'(fwd_sel));
    endtask

    task automatic cnt();
        push("stall_cnt", 32'(exp_stall));
        push("flush_cnt", 32'(exp_flush));
        pop_chk(32'(stall_cnt));
        pop_chk(32'(flush_cnt));
    endtask

    task automatic bump_stall();
        if (exp_stall < CNT_MAX) exp_stall++;
    endtask

    task automatic bump_flush();
        if (exp_flush < CNT_MAX) exp_flush++;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                            input logic [1:0] used, input logic [4:0] rd, input logic rw,
                            input logic mr, input logic jmp, input logic br);
        id_valid         = v;
        id_src           = {s1, s0};
        id_src_used      = used;
        id_rd            = rd;
        id_regwrite      = rw;
        id_memread       = mr;
        id_jump          = jmp;
        mem_branch_taken = br;
    endtask

    task automatic nop();
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with redirect/jump driven: outputs must stay idle
        reset = 1'b1;
        drive_id(1'b1, 5'd2, 5'd2, 2'b11, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        #12;
        exp_ctrl(1, 1, 0, 0, 0); chk_ctrl();
        fwd(4'b0000);
        cnt();
        nop();
        @(negedge clk);
        reset = 1'b0;
        tick();

        // lw $2 ; add $3,$2,$4 -> one stall, then MEM/WB forward on slot0
        drive_id(1, 5'd0, 5'd0, 2'b00, 5'd2, 1, 1, 0, 0);
        #2 exp_ctrl(1, 1, 0, 0, 0); chk_ctrl();
        tick();
        drive_id(1, 5'd2, 5'd4, 2'b11, 5'd3, 1, 0, 0, 0);
        #2 exp_ctrl(0, 0, 0, 1, 0); chk_ctrl(); bump_stall();
        tick();
        #2 exp_ctrl(1, 1, 0, 0, 0); chk_ctrl(); fwd(4'b0000);
        tick();
        nop();
        #2 fwd(4'b0001); cnt();

        // add $5 ; sub $6,$5,$5 -> EX/MEM on both slots
        tick();
        drive_id(1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 0, 0, 0);
        tick();
        drive_id(1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 0, 0, 0);
        #2 exp_ctrl(1, 1, 0, 0, 0); chk_ctrl();
        tick();
        nop();
        #2 fwd(4'b1010);

        // add $5 ; nop ; or $7,$5,$1 -> MEM/WB on slot0
        tick();
        drive_id(1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 0, 0, 0);
        tick();
        nop();
        tick();
        drive_id(1, 5'd5, 5'd1, 2'b11, 5'd7, 1, 0, 0, 0);
        tick();
        nop();
        #2 fwd(4'b0001);

        // add $5 ; add $5 ; or $7,$5,$1 -> younger writer wins: EX/MEM
        tick();
        drive_id(1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 0, 0, 0);
        tick();
        drive_id(1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 0, 0, 0);
        tick();
        drive_id(1, 5'd5, 5'd1, 2'b11, 5'd7, 1, 0, 0, 0);
        tick();
        nop();
        #2 fwd(4'b0010);

        // lw $0 ; reader of $0 -> no stall, no forward
        tick();
        drive_id(1, 5'd0, 5'd0, 2'b00, 5'd0, 1, 1, 0, 0);
        tick();
        drive_id(1, 5'd0, 5'd0, 2'b11, 5'd8, 1, 0, 0, 0);
        #2 exp_ctrl(1, 1, 0, 0, 0); chk_ctrl();
        tick();
        nop();
        #2 fwd(4'b0000);

        // Plain jump -> IF/ID flush only
        tick();
        drive_id(1, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 1, 0);
        #2 exp_ctrl(1, 1, 1, 0, 0); chk_ctrl(); bump_flush();
        tick();
        nop();
        #2 cnt();

        // Load-use on a jump: stall first, jump takes effect on the replay
        tick();
        drive_id(1, 5'd0, 5'd0, 2'b00, 5'd2, 1, 1, 0, 0);
        tick();
        drive_id(1, 5'd2, 5'd0, 2'b01, 5'd0, 0, 0, 1, 0);
        #2 exp_ctrl(0, 0, 0, 1, 0); chk_ctrl(); bump_stall();
        tick();
        #2 exp_ctrl(1, 1, 1, 0, 0); chk_ctrl(); bump_flush();
        tick();
        nop();
        #2 cnt();

        // Redirect coincident with load-use and jump
        tick();
        drive_id(1, 5'd0, 5'd0, 2'b00, 5'd9, 1, 0, 0, 0);
        tick();
        drive_id(1, 5'd0, 5'd0, 2'b00, 5'd2, 1, 1, 0, 0);
        tick();
        drive_id(1, 5'd2, 5'd0, 2'b01, 5'd3, 1, 0, 1, 1);
        #2 exp_ctrl(1, 1, 1, 1, 1); chk_ctrl(); bump_flush();
        tick();
        drive_id(1, 5'd9, 5'd2, 2'b11, 5'd10, 1, 0, 0, 0);
        #2 exp_ctrl(1, 1, 0, 0, 0); chk_ctrl(); cnt();
        tick();
        nop();
        #2 fwd(4'b0000);

        // Three more load-use pairs: stall counter saturates
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_id(1, 5'd0, 5'd0, 2'b00, 5'd2, 1, 1, 0, 0);
            tick();
            drive_id(1, 5'd4, 5'd2, 2'b10, 5'd3, 1, 0, 0, 0);
            #2 exp_ctrl(0, 0, 0, 1, 0); chk_ctrl(); bump_stall();
            tick();
        end
        nop();
        #2 cnt();

        // Asynchronous reset in the middle of a stall
        tick();
        drive_id(1, 5'd0, 5'd0, 2'b00, 5'd2, 1, 1, 0, 0);
        tick();
        drive_id(1, 5'd2, 5'd0, 2'b01, 5'd3, 1, 0, 0, 0);
        #2 exp_ctrl(0, 0, 0, 1, 0); chk_ctrl();
        mem_branch_taken = 1'b1;
        id_jump          = 1'b1;
        #1 reset = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        exp_ctrl(1, 1, 0, 0, 0); chk_ctrl();
        cnt();
        fwd(4'b0000);
        nop();
        @(negedge clk);
        reset = 1'b0;

        // First edge after release sees an empty pipeline
        tick();
        drive_id(1, 5'd2, 5'd0, 2'b01, 5'd3, 1, 0, 0, 0);
        #2 exp_ctrl(1, 1, 0, 0, 0); chk_ctrl();
        tick();
        nop();
        #2 fwd(4'b0000); cnt();

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
